sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock, parametrised FIFO with programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags and a selectable first-word-fall-through read mode. It is the general-purpose buffer for same-clock producer/consumer paths. Pointer and flag handling stay in one clock domain, so no synchronisers are needed.

## Interface
- DATA, 8, word width in bits
- ADD, 3, address width; DEPTH = 1<<ADD entries
- AF_LEVEL, 6, almost_full asserts when count >= AF_LEVEL
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through
- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-low reset
- w_en  input  1  write request
- wdata  input  DATA  write data
- r_en  input  1  read request (pop in FWFT mode)
- clr_err  input  1  synchronous clear of overflow/underflow
- rdata  output  DATA  read data
- full, empty  output  1  occupancy flags
- almost_full, almost_empty  output  1  threshold flags
- count  output  ADD+1  entries held, 0..DEPTH
- overflow, underflow  output  1  sticky error flags

## Operation
- Legal parameters: ADD >= 1 and 0 <= AE_LEVEL < AF_LEVEL <= DEPTH. The design elaborates an error otherwise.
- Pointers:
  - wptr and rptr are ADD+1-bit binary; the low ADD bits address memory and the MSB is the wrap bit.
  - Increment is modulo 2^(ADD+1).
- Occupancy flags:
  - empty = (wptr == rptr).
  - full = (MSBs differ) and (low ADD bits equal).
  - count = wptr - rptr, modulo 2^(ADD+1).
- Write accepted (wr_ok) = w_en & ~full. On wr_ok, mem[wptr] <= wdata and wptr increments.
- Read accepted (rd_ok) = r_en & ~empty. On rd_ok, rptr increments.
- Simultaneous wr_ok and rd_ok: both happen; count is unchanged.
- Full with w_en and r_en: the read is accepted, the write is rejected, and overflow sets.
- Empty with w_en and r_en: the write is accepted, the read is rejected, and underflow sets.
- FWFT=0: rdata is a register. It loads mem[rptr] on an rd_ok edge and holds otherwise.
- FWFT=1:
  - rdata = mem[rptr] combinationally; it is valid whenever empty=0.
  - When empty=1, rdata is undefined and must not be checked.
- Error flags:
  - overflow sets on any edge with w_en & full.
  - underflow sets on any edge with r_en & empty.
  - Both clear on an edge with clr_err. If set and clear occur on the same edge, set wins.
- Memory contents are not reset. Reset discards all stored data.

## Timing
- Reset (rst low, asynchronous):
  - wptr=rptr=0 and count=0.
  - empty=1, full=0, almost_empty=1.
  - almost_full=0; it is 1 only if AF_LEVEL=0, which is illegal.
  - overflow=underflow=0 and rdata=0.
- Reset asserted mid-operation takes effect immediately, not at the next clock edge.
- Release is synchronous to the next clk edge.
- All flags and count derive from registered pointers. They update in the cycle after the accepting edge.
- Write-to-read latency:
  - Word written at edge N; empty falls after edge N.
  - FWFT=1: rdata is valid after edge N.
  - FWFT=0: r_en sampled at edge N+1 puts the word on rdata after edge N+1.
- Throughput: one write and one read per cycle, sustained, at any occupancy strictly between empty and full.
- Wrap-around: after 2*DEPTH writes, the pointer MSB has toggled twice. Flags stay correct across the wrap with no bubbles.

## Structure
- sync_fifo_pkg holds:
  - localparam helpers: DEPTH, and count width ADD+1.
  - A function checking parameter legality, used by an elaboration-time assertion.
- One sub-module, fifo_ptr: an ADD+1-bit binary pointer with increment-enable and async active-low reset. It is instantiated twice, once for write and once for read.
- The memory array, flag logic and FWFT mux stay in sync_fifo.

## Test plan
- Reset with w_en=r_en=1 held: outputs show count=0, empty=1, almost_empty=1, full=0 and all error flags 0 until release.
- ADD=3, FWFT=0: write 8 words 0x01..0x08.
  - Flags: almost_full rises when count reaches 6; full=1 after the 8th write.
  - 9th write: overflow=1 and memory is unchanged.
  - Drain: rdata shows 0x01..0x08 in order; empty=1 after the last read.
- FWFT=1: write 0xA5 into an empty FIFO. On the next cycle, rdata=0xA5 with r_en low; one r_en pulse returns empty=1.
- Simultaneous read and write at count=4 for 20 cycles: count holds at 4, the data sequence is preserved, and both pointers wrap at least twice.
- r_en while empty: underflow=1 and count stays 0. Then clr_err and r_en&empty on the same edge: underflow stays 1. clr_err alone clears it.
- Assert rst mid-burst at count=5: all outputs return to reset values immediately. Subsequent writes start at address 0.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// sync_fifo shared helpers.
// Sizing functions and parameter legality check.
package sync_fifo_pkg;

  function automatic int depth_of(input int add);
    return 1 << add;
  endfunction

  function automatic int cnt_w(input int add);
    return add + 1;
  endfunction

  function automatic bit params_ok(
    input int add,
    input int af,
    input int ae
  );
    return (add >= 1) && (ae >= 0) &&
           (ae < af) && (af <= (1 << add));
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Binary FIFO pointer with wrap bit.
// Increments modulo 2^W on inc.
module fifo_ptr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ptr <= '0;
    else if (inc)
      ptr <= ptr + 1'b1;
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with thresholds, sticky errors
// and optional first-word-fall-through read.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA     = 8,
  parameter int ADD      = 3,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2,
  parameter bit FWFT     = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            w_en,
  input  logic [DATA-1:0] wdata,
  input  logic            r_en,
  input  logic            clr_err,
  output logic [DATA-1:0] rdata,
  output logic            full,
  output logic            empty,
  output logic            almost_full,
  output logic            almost_empty,
  output logic [ADD:0]    count,
  output logic            overflow,
  output logic            underflow
);

  localparam int DEPTH = depth_of(ADD);
  localparam int CW    = cnt_w(ADD);

  localparam logic [CW-1:0] AF_L = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_L = CW'(AE_LEVEL);

  if (!params_ok(ADD, AF_LEVEL, AE_LEVEL)) begin : g_bad
    $error("sync_fifo: illegal ADD/AF_LEVEL/AE_LEVEL");
  end

  logic [DATA-1:0] mem [DEPTH];
  logic [ADD:0]    wptr;
  logic [ADD:0]    rptr;
  logic            wr_ok;
  logic            rd_ok;

  assign wr_ok = w_en & ~full;
  assign rd_ok = r_en & ~empty;

  fifo_ptr #(.W(CW)) u_wptr (
    .clk (clk),
    .rst (rst),
    .inc (wr_ok),
    .ptr (wptr)
  );

  fifo_ptr #(.W(CW)) u_rptr (
    .clk (clk),
    .rst (rst),
    .inc (rd_ok),
    .ptr (rptr)
  );

  assign empty = (wptr == rptr);
  assign full  = (wptr[ADD] != rptr[ADD]) &&
                 (wptr[ADD-1:0] == rptr[ADD-1:0]);
  assign count = wptr - rptr;

  assign almost_full  = (count >= AF_L);
  assign almost_empty = (count <= AE_L);

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wptr[ADD-1:0]] <= wdata;
  end

  // A set on the same edge as clr_err wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_en && full)
        overflow <= 1'b1;
      else if (clr_err)
        overflow <= 1'b0;
      if (r_en && empty)
        underflow <= 1'b1;
      else if (clr_err)
        underflow <= 1'b0;
    end
  end

  if (FWFT) begin : g_fwft
    assign rdata = mem[rptr[ADD-1:0]];
  end else begin : g_reg
    logic [DATA-1:0] rdata_q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)
        rdata_q <= '0;
      else if (rd_ok)
        rdata_q <= mem[rptr[ADD-1:0]];
    end
    assign rdata = rdata_q;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed scoreboard bench for sync_fifo,
// registered-read and FWFT instances side by side.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst;

  logic       w_en0, r_en0, clr0;
  logic [7:0] wdata0, rdata0;
  logic       full0, empty0, af0, ae0, ovf0, udf0;
  logic [3:0] count0;

  logic       w_en1, r_en1, clr1;
  logic [7:0] wdata1, rdata1;
  logic       full1, empty1, af1, ae1, ovf1, udf1;
  logic [3:0] count1;

  int nvec = 0;
  int nerr = 0;
  logic [7:0] sb0[$];
  logic [7:0] sb1[$];
  logic [7:0] nxt;

  always #5 clk = ~clk;

  sync_fifo #(
    .DATA(8), .ADD(3), .AF_LEVEL(6),
    .AE_LEVEL(2), .FWFT(1'b0)
  ) dut0 (
    .clk(clk), .rst(rst),
    .w_en(w_en0), .wdata(wdata0),
    .r_en(r_en0), .clr_err(clr0),
    .rdata(rdata0), .full(full0),
    .empty(empty0), .almost_full(af0),
    .almost_empty(ae0), .count(count0),
    .overflow(ovf0), .underflow(udf0)
  );

  sync_fifo #(
    .DATA(8), .ADD(3), .AF_LEVEL(6),
    .AE_LEVEL(2), .FWFT(1'b1)
  ) dut1 (
    .clk(clk), .rst(rst),
    .w_en(w_en1), .wdata(wdata1),
    .r_en(r_en1), .clr_err(clr1),
    .rdata(rdata1), .full(full1),
    .empty(empty1), .almost_full(af1),
    .almost_empty(ae1), .count(count1),
    .overflow(ovf1), .underflow(udf1)
  );

  task automatic chk(
    input string       tag,
    input int unsigned obs,
    input int unsigned exp
  );
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop0(input string tag);
    logic [7:0] e;
    if (sb0.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb0.pop_front();
      chk(tag, rdata0, e);
    end
  endtask

  task automatic pop1(input string tag);
    logic [7:0] e;
    if (sb1.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb1.pop_front();
      chk(tag, rdata1, e);
    end
  endtask

  task automatic chk_reset0(input string tag);
    chk({tag, "_count"}, count0, 0);
    chk({tag, "_empty"}, empty0, 1);
    chk({tag, "_ae"}, ae0, 1);
    chk({tag, "_full"}, full0, 0);
    chk({tag, "_af"}, af0, 0);
    chk({tag, "_ovf"}, ovf0, 0);
    chk({tag, "_udf"}, udf0, 0);
    chk({tag, "_rdata"}, rdata0, 0);
  endtask

  initial begin
    rst = 1'b0;
    w_en0 = 1'b1; r_en0 = 1'b1; clr0 = 1'b0;
    w_en1 = 1'b1; r_en1 = 1'b1; clr1 = 1'b0;
    wdata0 = 8'hEE; wdata1 = 8'hEE;

    // reset held with requests active
    step();
    step();
    chk_reset0("rst");
    chk("rst_count1", count1, 0);
    chk("rst_empty1", empty1, 1);
    chk("rst_ovf1", ovf1, 0);
    w_en0 = 1'b0; r_en0 = 1'b0;
    w_en1 = 1'b0; r_en1 = 1'b0;
    rst = 1'b1;
    step();
    chk("post_rel_count", count0, 0);

    // fill 0x01..0x08
    for (int k = 1; k <= 8; k++) begin
      w_en0 = 1'b1;
      wdata0 = 8'(k);
      sb0.push_back(8'(k));
      step();
      chk($sformatf("fill_count%0d", k), count0, k);
      chk($sformatf("fill_af%0d", k), af0, k >= 6);
      chk($sformatf("fill_full%0d", k), full0, k == 8);
      chk($sformatf("fill_ae%0d", k), ae0, k <= 2);
    end

    // 9th write rejected, overflow sticks
    wdata0 = 8'hFF;
    step();
    w_en0 = 1'b0;
    chk("ovf_set", ovf0, 1);
    chk("ovf_count", count0, 8);
    chk("ovf_full", full0, 1);
    step();
    chk("ovf_sticky", ovf0, 1);
    clr0 = 1'b1;
    step();
    clr0 = 1'b0;
    chk("ovf_clr", ovf0, 0);

    // drain in order
    for (int k = 1; k <= 8; k++) begin
      r_en0 = 1'b1;
      step();
      pop0($sformatf("drain%0d", k));
      chk($sformatf("drain_count%0d", k), count0, 8 - k);
    end
    r_en0 = 1'b0;
    chk("drain_empty", empty0, 1);
    chk("drain_udf", udf0, 0);

    // underflow, set beats clear
    r_en0 = 1'b1;
    step();
    chk("udf_set", udf0, 1);
    chk("udf_count", count0, 0);
    clr0 = 1'b1;
    step();
    chk("udf_set_wins", udf0, 1);
    r_en0 = 1'b0;
    step();
    clr0 = 1'b0;
    chk("udf_clr", udf0, 0);

    // prime to 4, then 20 cycles of read+write
    nxt = 8'h40;
    for (int k = 0; k < 4; k++) begin
      w_en0 = 1'b1;
      wdata0 = nxt;
      sb0.push_back(nxt);
      nxt++;
      step();
    end
    chk("prime_count", count0, 4);
    r_en0 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      wdata0 = nxt;
      sb0.push_back(nxt);
      nxt++;
      step();
      pop0($sformatf("rw_data%0d", k));
      chk($sformatf("rw_count%0d", k), count0, 4);
    end
    r_en0 = 1'b0;
    chk("rw_full", full0, 0);
    chk("rw_empty", empty0, 0);

    // one more to 5, then async reset mid-burst
    wdata0 = 8'h99;
    step();
    chk("pre_rst_count", count0, 5);
    wdata0 = 8'h77;
    #2;
    rst = 1'b0;
    #1;
    chk_reset0("mid_rst");
    sb0.delete();
    step();
    chk("mid_rst_hold", count0, 0);
    rst = 1'b1;
    wdata0 = 8'h5A;
    sb0.push_back(8'h5A);
    step();
    w_en0 = 1'b0;
    chk("after_rst_count", count0, 1);
    r_en0 = 1'b1;
    step();
    r_en0 = 1'b0;
    pop0("after_rst_data");
    chk("after_rst_empty", empty0, 1);

    // FWFT: word visible without a read
    w_en1 = 1'b1;
    wdata1 = 8'hA5;
    sb1.push_back(8'hA5);
    step();
    w_en1 = 1'b0;
    chk("fwft_empty", empty1, 0);
    step();
    pop1("fwft_data");
    r_en1 = 1'b1;
    step();
    r_en1 = 1'b0;
    chk("fwft_pop_empty", empty1, 1);
    chk("fwft_udf", udf1, 0);

    // FWFT: head advances on each pop
    w_en1 = 1'b1;
    wdata1 = 8'h11;
    sb1.push_back(8'h11);
    step();
    wdata1 = 8'h22;
    sb1.push_back(8'h22);
    step();
    w_en1 = 1'b0;
    pop1("fwft_head0");
    r_en1 = 1'b1;
    step();
    pop1("fwft_head1");
    step();
    r_en1 = 1'b0;
    chk("fwft_drained", empty1, 1);
    chk("fwft_count", count1, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
